// File: rtl/spike_aer_tx_pkg.sv
// ---------------------------------------------------------------------------
// snn_aer_pkg
// Shared definitions for the AER (address-event) packet format, used by the
// spike transmitter now and by the matching receiver later.
//
// Packet layout for an ADDR_WIDTH-bit payload:
//   [ADDR_WIDTH]     type bit (AER_SPIKE or AER_EOT)
//   [ADDR_WIDTH-1:0] neuron address, or zero-extended timestep for EOT
// ---------------------------------------------------------------------------
package snn_aer_pkg;

  // Default payload width of the network's neuron address space.
  localparam int AER_ADDR_W = 14;

  // Packet type encodings carried in the type bit.
  localparam logic AER_SPIKE = 1'b0;
  localparam logic AER_EOT   = 1'b1;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_EOT
  } aer_tx_state_t;

  // The type bit sits directly above the payload, so its index equals the
  // payload width. Kept as a function so transmitter and receiver agree.
  function automatic int aerTypePos(input int addrWidth);
    return addrWidth;
  endfunction

endpackage

// File: rtl/spike_aer_tx_if.sv
// ---------------------------------------------------------------------------
// spike_aer_tx_if
// Valid/ready AER word stream between the spike transmitter and the
// fan-out/router logic.
//
// Signals:
//   aer_valid  word valid (master -> slave)
//   aer_data   {type, payload}, ADDR_WIDTH+1 bits (master -> slave)
//   aer_ready  slave accepts the word when valid && ready (slave -> master)
// ---------------------------------------------------------------------------
interface spike_aer_tx_if #(
  parameter int ADDR_WIDTH = 14
);

  logic                  aer_valid;
  logic [ADDR_WIDTH:0]   aer_data;
  logic                  aer_ready;

  modport master (
    output aer_valid,
    output aer_data,
    input  aer_ready
  );

  modport slave (
    input  aer_valid,
    input  aer_data,
    output aer_ready
  );

endinterface

// File: rtl/spike_aer_tx.sv
// ---------------------------------------------------------------------------
// spike_aer_tx
// Drains the spike FIFO written by the TDM controller and sends each neuron
// address as an AER spike word. After the controller reports the timestep is
// done and the FIFO has drained, one end-of-timestep (EOT) word carrying the
// timestep number is sent. Spikes per timestep are counted and published.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous active-high reset
//   i_fifo_empty        spike FIFO empty flag
//   o_fifo_rd_en        spike FIFO pop strobe
//   i_fifo_rd_data      popped address, valid FIFO_RD_LAT cycles after pop
//   i_processing_done   one-cycle "timestep finished" pulse
//   aer                 AER valid/ready stream (master side)
//   o_busy              FSM active or an EOT is pending
//   o_ts_spike_count    spikes sent in the last completed timestep
//   o_err_done_overrun  sticky: done arrived while an EOT was still pending
//
// TS_WIDTH must not exceed ADDR_WIDTH. FIFO_RD_LAT must be 1 or 2.
// ---------------------------------------------------------------------------
module spike_aer_tx
  import snn_aer_pkg::*;
#(
  parameter int ADDR_WIDTH  = AER_ADDR_W,
  parameter int TS_WIDTH    = 8,
  parameter int FIFO_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_fifo_rd_data,
  input  logic                  i_processing_done,
  spike_aer_tx_if.master        aer,
  output logic                  o_busy,
  output logic [ADDR_WIDTH:0]   o_ts_spike_count,
  output logic                  o_err_done_overrun
);

  localparam int                TypePos = aerTypePos(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] CntOne = (ADDR_WIDTH+1)'(1);
  localparam logic [TS_WIDTH-1:0] TsOne  = TS_WIDTH'(1);

  aer_tx_state_t         r_state;
  logic                  r_aerValid;
  logic [ADDR_WIDTH:0]   r_aerData;
  logic [ADDR_WIDTH:0]   r_spikeCnt;
  logic [ADDR_WIDTH:0]   r_tsSpikeCount;
  logic [TS_WIDTH-1:0]   r_tsCnt;
  logic                  r_donePending;
  logic [1:0]            r_pendAge;
  logic                  r_errOverrun;

  logic                  w_accept;
  logic                  w_eotAccept;
  logic                  w_pendQual;

  // A word leaves on valid && ready; an EOT leaving is what retires the
  // pending done request.
  assign w_accept    = r_aerValid && aer.aer_ready;
  assign w_eotAccept = (r_state == S_EOT) && w_accept;

  // The pending done only counts once it has been held for two full cycles,
  // which covers the FIFO empty flag lagging the controller's last write.
  assign w_pendQual  = r_donePending && (r_pendAge == 2'd2);

  // The pop strobe is decoded from state so it lines up with the empty flag
  // of the same cycle; gating with rst drops it as soon as reset rises.
  assign o_fifo_rd_en = (r_state == S_IDLE) && !i_fifo_empty && !rst;

  assign aer.aer_valid      = r_aerValid;
  assign aer.aer_data       = r_aerData;
  assign o_busy             = (r_state != S_IDLE) || r_donePending;
  assign o_ts_spike_count   = r_tsSpikeCount;
  assign o_err_done_overrun = r_errOverrun;

  // Main FSM plus the done-pending tracker and statistics counters. An
  // accepted EOT frees the pending slot in the same cycle, so a done pulse
  // landing exactly then re-arms it instead of flagging an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_aerValid     <= 1'b0;
      r_aerData      <= '0;
      r_spikeCnt     <= '0;
      r_tsSpikeCount <= '0;
      r_tsCnt        <= '0;
      r_donePending  <= 1'b0;
      r_pendAge      <= 2'd0;
      r_errOverrun   <= 1'b0;
    end else begin
      if (w_eotAccept || !r_donePending) begin
        if (i_processing_done) begin
          r_donePending <= 1'b1;
          r_pendAge     <= 2'd0;
        end else if (w_eotAccept) begin
          r_donePending <= 1'b0;
          r_pendAge     <= 2'd0;
        end
      end else begin
        if (i_processing_done) begin
          r_errOverrun <= 1'b1;
        end
        if (r_pendAge != 2'd2) begin
          r_pendAge <= r_pendAge + 2'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (!i_fifo_empty) begin
            r_state <= S_READ;
          end else if (w_pendQual) begin
            r_state    <= S_EOT;
            r_aerValid <= 1'b1;
            r_aerData  <= {AER_EOT, ADDR_WIDTH'(r_tsCnt)};
          end
        end
        S_READ: begin
          if (FIFO_RD_LAT == 1) begin
            r_state    <= S_SEND;
            r_aerValid <= 1'b1;
            r_aerData  <= {AER_SPIKE, i_fifo_rd_data};
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_state    <= S_SEND;
          r_aerValid <= 1'b1;
          r_aerData  <= {AER_SPIKE, i_fifo_rd_data};
        end
        S_SEND: begin
          if (w_accept) begin
            r_state    <= S_IDLE;
            r_aerValid <= 1'b0;
            if (r_spikeCnt != '1) begin
              r_spikeCnt <= r_spikeCnt + CntOne;
            end
          end
        end
        S_EOT: begin
          if (w_accept) begin
            r_state        <= S_IDLE;
            r_aerValid     <= 1'b0;
            r_tsSpikeCount <= r_spikeCnt;
            r_spikeCnt     <= '0;
            r_tsCnt        <= r_tsCnt + TsOne;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_aerValid <= 1'b0;
        end
      endcase

      // Keep the type bit index tied to the shared packet layout.
      if (TypePos != ADDR_WIDTH) begin
        r_aerValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_aer_tx.sv
// ---------------------------------------------------------------------------
// tb_spike_aer_tx
// Directed bench for spike_aer_tx with the default parameters
// (ADDR_WIDTH=14, TS_WIDTH=8, FIFO_RD_LAT=1). A small FIFO model sits in
// front of the DUT; its empty flag lags pushes and pops by one cycle like the
// real spike FIFO. Accepted AER words are collected into a queue.
// ---------------------------------------------------------------------------
module tb_spike_aer_tx;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifoEmpty = 1'b1;
  logic          rdEn;
  logic [AW-1:0] rdData = '0;
  logic          done;
  logic          busy;
  logic [AW:0]   tsCount;
  logic          errOverrun;
  logic          pushEn;
  logic [AW-1:0] pushData;

  logic [AW-1:0] fifoQ[$];
  logic [AW:0]   acc[$];

  int checks = 0;
  int errors = 0;
  int rdCount = 0;
  int rdWhileEmpty = 0;
  int rdSnap = 0;

  spike_aer_tx_if #(.ADDR_WIDTH(AW)) aerIf ();

  spike_aer_tx #(
    .ADDR_WIDTH (AW),
    .TS_WIDTH   (8),
    .FIFO_RD_LAT(1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_fifo_empty      (fifoEmpty),
    .o_fifo_rd_en      (rdEn),
    .i_fifo_rd_data    (rdData),
    .i_processing_done (done),
    .aer               (aerIf.master),
    .o_busy            (busy),
    .o_ts_spike_count  (tsCount),
    .o_err_done_overrun(errOverrun)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Spike FIFO model: one-cycle read latency, empty flag computed from the
  // occupancy before this edge's push/pop so it trails the contents by a cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifoQ.delete();
      fifoEmpty <= 1'b1;
      rdData    <= '0;
    end else begin
      fifoEmpty <= (fifoQ.size() == 0);
      if (rdEn && fifoQ.size() > 0) begin
        rdData <= fifoQ.pop_front();
      end
      if (pushEn) begin
        fifoQ.push_back(pushData);
      end
    end
  end

  // Collects every accepted AER word and watches the pop strobe.
  always @(posedge clk) begin
    if (rdEn) begin
      rdCount++;
      if (fifoEmpty) begin
        rdWhileEmpty++;
      end
    end
    if (aerIf.aer_valid && aerIf.aer_ready) begin
      acc.push_back(aerIf.aer_data);
    end
  end

  // Hard stop in case something never terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of push/done stimulus; call and return on a negedge.
  task automatic applyStimulus(input bit doPush, input logic [AW-1:0] addr,
                               input bit doDone);
    pushEn   = doPush;
    pushData = addr;
    done     = doDone;
    @(negedge clk);
    pushEn = 1'b0;
    done   = 1'b0;
  endtask

  task automatic waitWords(input int n, input int budget);
    for (int i = 0; i < budget && acc.size() < n; i++) begin
      @(negedge clk);
    end
  endtask

  task automatic waitValid(input int budget);
    for (int i = 0; i < budget && aerIf.aer_valid !== 1'b1; i++) begin
      @(negedge clk);
    end
  endtask

  // Linear directed sequence.
  initial begin
    rst             = 1'b1;
    pushEn          = 1'b0;
    pushData        = '0;
    done            = 1'b0;
    aerIf.aer_ready = 1'b1;

    #12;
    checkOutput("rst_valid", 32'(aerIf.aer_valid), 32'd0);
    checkOutput("rst_data", 32'(aerIf.aer_data), 32'd0);
    checkOutput("rst_rd_en", 32'(rdEn), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ts_count", 32'(tsCount), 32'd0);
    checkOutput("rst_err", 32'(errOverrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] three spikes then EOT for timestep 0");
    applyStimulus(1'b1, 14'd5, 1'b0);
    applyStimulus(1'b1, 14'd9999, 1'b0);
    applyStimulus(1'b1, 14'd0, 1'b0);
    applyStimulus(1'b0, 14'd0, 1'b1);
    waitWords(4, 60);
    checkOutput("t1_count", 32'(acc.size()), 32'd4);
    checkOutput("t1_w0", 32'(acc[0]), 32'h00005);
    checkOutput("t1_w1", 32'(acc[1]), 32'h0270F);
    checkOutput("t1_w2", 32'(acc[2]), 32'h00000);
    checkOutput("t1_eot", 32'(acc[3]), 32'h04000);
    checkOutput("t1_ts_count", 32'(tsCount), 32'd3);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    acc.delete();

    $display("[TB] backpressure on address 42");
    aerIf.aer_ready = 1'b0;
    applyStimulus(1'b1, 14'd42, 1'b0);
    waitValid(10);
    checkOutput("bp_valid", 32'(aerIf.aer_valid), 32'd1);
    rdSnap = rdCount;
    applyStimulus(1'b1, 14'd7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_hold", {15'd0, aerIf.aer_valid, 2'd0, aerIf.aer_data},
                  {15'd0, 1'b1, 2'd0, 15'h0002A});
      @(negedge clk);
    end
    checkOutput("bp_no_pop", 32'(rdCount - rdSnap), 32'd0);
    checkOutput("bp_no_accept", 32'(acc.size()), 32'd0);
    aerIf.aer_ready = 1'b1;
    waitWords(2, 40);
    repeat (10) @(negedge clk);
    checkOutput("bp_words", 32'(acc.size()), 32'd2);
    checkOutput("bp_w0", 32'(acc[0]), 32'h0002A);
    checkOutput("bp_w1", 32'(acc[1]), 32'h00007);
    acc.delete();
    applyStimulus(1'b0, 14'd0, 1'b1);
    waitWords(1, 20);
    checkOutput("bp_eot", 32'(acc[0]), 32'h04001);
    checkOutput("bp_ts_count", 32'(tsCount), 32'd2);
    acc.delete();

    $display("[TB] empty timestep, then done with last write");
    applyStimulus(1'b0, 14'd0, 1'b1);
    waitWords(1, 20);
    checkOutput("empty_eot", 32'(acc[0]), 32'h04002);
    checkOutput("empty_ts_count", 32'(tsCount), 32'd0);
    acc.delete();
    applyStimulus(1'b1, 14'd123, 1'b1);
    waitWords(2, 30);
    checkOutput("same_words", 32'(acc.size()), 32'd2);
    checkOutput("same_spike", 32'(acc[0]), 32'h0007B);
    checkOutput("same_eot", 32'(acc[1]), 32'h04003);
    checkOutput("same_ts_count", 32'(tsCount), 32'd1);
    acc.delete();

    $display("[TB] done overrun with ready low");
    aerIf.aer_ready = 1'b0;
    applyStimulus(1'b0, 14'd0, 1'b1);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 14'd0, 1'b1);
    checkOutput("ovr_err", 32'(errOverrun), 32'd1);
    checkOutput("ovr_valid", 32'(aerIf.aer_valid), 32'd1);
    checkOutput("ovr_data", 32'(aerIf.aer_data), 32'h04004);
    repeat (5) @(negedge clk);
    aerIf.aer_ready = 1'b1;
    waitWords(1, 20);
    repeat (15) @(negedge clk);
    checkOutput("ovr_words", 32'(acc.size()), 32'd1);
    checkOutput("ovr_eot", 32'(acc[0]), 32'h04004);
    checkOutput("ovr_err_sticky", 32'(errOverrun), 32'd1);
    checkOutput("ovr_busy", 32'(busy), 32'd0);
    checkOutput("ovr_ts_count", 32'(tsCount), 32'd0);
    acc.delete();

    $display("[TB] reset while holding a spike");
    aerIf.aer_ready = 1'b0;
    applyStimulus(1'b1, 14'd77, 1'b0);
    waitValid(10);
    checkOutput("rs_held", 32'(aerIf.aer_data), 32'h0004D);
    applyStimulus(1'b1, 14'd88, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rs_valid", 32'(aerIf.aer_valid), 32'd0);
    checkOutput("rs_rd_en", 32'(rdEn), 32'd0);
    checkOutput("rs_err", 32'(errOverrun), 32'd0);
    checkOutput("rs_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    aerIf.aer_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 14'd0, 1'b1);
    waitWords(1, 20);
    repeat (5) @(negedge clk);
    checkOutput("rs_words", 32'(acc.size()), 32'd1);
    checkOutput("rs_eot", 32'(acc[0]), 32'h04000);
    acc.delete();

    $display("[TB] timestep counter wrap");
    for (int t = 1; t <= 256; t++) begin
      applyStimulus(1'b0, 14'd0, 1'b1);
      waitWords(1, 20);
      checkOutput("wrap_eot", 32'(acc[0]), 32'h04000 | 32'(t % 256));
      acc.delete();
    end

    checkOutput("rd_while_empty", 32'(rdWhileEmpty), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
